pipe_lane_adder: RTL and testbench

Parametrised, flow-controlled pipelined adder: each of LANES lanes takes a 2·WIDTH-bit word, splits it into upper half `a` and lower half `b`, and produces `a + b` modulo 2^WIDTH.
- Successor to the fixed 64→32-bit, free-running, three-register half-adder pipeline.
- Adds the following:
  - configurable width, lane count and depth;
  - valid/ready handshake with backpressure and bubble collapsing;
  - asynchronous reset;
  - occupancy reporting.
- Sits between a packed-operand producer and a result consumer in the datapath.

---
 rtl/pipe_lane_adder.sv | 114 +++++++++++
 tb/tb_pipe_lane_adder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_lane_adder.sv
// Flow-controlled, multi-lane pipelined adder: each lane adds the upper and lower halves of its input slice.
// Optional per-lane carry-out is enabled by defining PIPE_LANE_ADDER_CARRY_EN.
module pipe_lane_adder #(
    parameter int WIDTH  = 32,
    parameter int LANES  = 1,
    parameter int STAGES = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*2*WIDTH-1:0]       in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*WIDTH-1:0]         out_data,
    output logic [$clog2(STAGES+1)-1:0]    occupancy
`ifdef PIPE_LANE_ADDER_CARRY_EN
    ,
    output logic [LANES-1:0]               carry
`endif
);

    localparam int OCC_W = $clog2(STAGES + 1);
`ifdef PIPE_LANE_ADDER_CARRY_EN
    localparam int RES_W = WIDTH + 1;
`else
    localparam int RES_W = WIDTH;
`endif

    logic [STAGES-1:0]          valid_q;
    logic [STAGES-1:0]          adv;
    logic                       all_valid;
    logic [LANES*2*WIDTH-1:0]   operand_q;
    logic [LANES*RES_W-1:0]     result_q [1:STAGES-1];
    logic [LANES*RES_W-1:0]     sum;

    // A stage may advance unless it and every stage downstream of it are full and the consumer stalls.
    always_comb begin
        all_valid = 1'b1;
        adv       = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_valid = all_valid & valid_q[k];
            adv[k]    = out_ready | ~all_valid;
        end
    end

    assign in_ready = adv[0];

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum[i*RES_W +: RES_W] = RES_W'(operand_q[i*2*WIDTH + WIDTH +: WIDTH])
                                  + RES_W'(operand_q[i*2*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_W'(valid_q[k]);
        end
    end

    // Data registers only load when a valid word arrives, so idle stages keep their old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            operand_q <= '0;
            for (int k = 1; k < STAGES; k++) begin
                result_q[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    operand_q <= in_data;
                end
            end
            if (adv[1]) begin
                valid_q[1] <= valid_q[0];
                if (valid_q[0]) begin
                    result_q[1] <= sum;
                end
            end
            for (int k = 2; k < STAGES; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        result_q[k] <= result_q[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];

    always_comb begin
        out_data = '0;
        for (int i = 0; i < LANES; i++) begin
            out_data[i*WIDTH +: WIDTH] = result_q[STAGES-1][i*RES_W +: WIDTH];
        end
    end

`ifdef PIPE_LANE_ADDER_CARRY_EN
    always_comb begin
        carry = '0;
        for (int i = 0; i < LANES; i++) begin
            carry[i] = result_q[STAGES-1][i*RES_W + WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_pipe_lane_adder.sv
// Directed self-checking bench for pipe_lane_adder (WIDTH=32, LANES=2, STAGES=3).
// Carry checks are included when PIPE_LANE_ADDER_CARRY_EN is defined.
module tb_pipe_lane_adder;

    localparam int WIDTH  = 32;
    localparam int LANES  = 2;
    localparam int STAGES = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*2*WIDTH-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*WIDTH-1:0]   out_data;
    logic [1:0]               occupancy;
`ifdef PIPE_LANE_ADDER_CARRY_EN
    logic [LANES-1:0]         carry;
`endif

    int assertions = 0;
    int failures   = 0;

    pipe_lane_adder #(.WIDTH(WIDTH), .LANES(LANES), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_LANE_ADDER_CARRY_EN
        ,
        .carry     (carry)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pack(input logic [31:0] a0, input logic [31:0] b0,
                                          input logic [31:0] a1, input logic [31:0] b1);
        return {a1, b1, a0, b0};
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic valid, input logic [127:0] data, input logic ready);
        @(negedge clk);
        in_valid  = valid;
        in_data   = data;
        out_ready = ready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic sendWord(input string tag, input logic [127:0] data, input logic [63:0] expected);
        applyStimulus(1'b1, data, 1'b1);
        checkOutput({tag, " in_ready"}, 64'(in_ready), 64'd1);
        for (int k = 1; k < STAGES; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput({tag, " early out_valid"}, 64'(out_valid), 64'd0);
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, " out_data"}, out_data, expected);
    endtask

    function automatic logic [63:0] bpExpected(input int n);
        return {32'hB2 + 32'(n), 32'hA1 + 32'(n)};
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        applyStimulus(1'b1, pack(32'h1, 32'h2, 32'h3, 32'h4), 1'b1);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset occupancy", 64'(occupancy), 64'd0);
        checkOutput("reset out_data", out_data, 64'd0);
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("reset no capture", 64'(occupancy), 64'd0);
        rst_n = 1'b1;

        sendWord("single", pack(32'h5, 32'h7, 32'h10000000, 32'h1), 64'h10000001_0000000C);
        checkOutput("single occupancy", 64'(occupancy), 64'd1);
`ifdef PIPE_LANE_ADDER_CARRY_EN
        checkOutput("single carry", 64'(carry), 64'd0);
`endif

        sendWord("wrap", pack(32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h80000000), 64'd0);
`ifdef PIPE_LANE_ADDER_CARRY_EN
        checkOutput("wrap carry", 64'(carry), 64'd3);
`endif

        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("drained out_valid", 64'(out_valid), 64'd0);

        for (int j = 0; j < 13; j++) begin
            if (j < 10) begin
                applyStimulus(1'b1, pack(32'h100, 32'(j), 32'h200, 32'(j)), 1'b1);
                checkOutput("stream in_ready", 64'(in_ready), 64'd1);
            end else begin
                applyStimulus(1'b0, '0, 1'b1);
            end
            if (j >= 3) begin
                checkOutput("stream out_valid", 64'(out_valid), 64'd1);
                checkOutput("stream out_data", out_data, {32'h200 + 32'(j - 3), 32'h100 + 32'(j - 3)});
            end
            if (j >= 3 && j <= 10) begin
                checkOutput("stream occupancy", 64'(occupancy), 64'd3);
            end
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("stream end out_valid", 64'(out_valid), 64'd0);

        // One word, two idle cycles, then three more against a stalled consumer.
        applyStimulus(1'b1, pack(32'hA0, 32'h1, 32'hB0, 32'h2), 1'b0);
        checkOutput("bp w0 in_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, pack(32'hA1, 32'h1, 32'hB1, 32'h2), 1'b0);
        checkOutput("bp w1 in_ready", 64'(in_ready), 64'd1);
        checkOutput("bp w0 held", out_data, bpExpected(0));
        applyStimulus(1'b1, pack(32'hA2, 32'h1, 32'hB2, 32'h2), 1'b0);
        checkOutput("bp w2 in_ready", 64'(in_ready), 64'd1);
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1'b1, pack(32'hA3, 32'h1, 32'hB3, 32'h2), 1'b0);
            checkOutput("bp full in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp full occupancy", 64'(occupancy), 64'd3);
            checkOutput("bp stall out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp stall out_data", out_data, bpExpected(0));
        end
        applyStimulus(1'b1, pack(32'hA3, 32'h1, 32'hB3, 32'h2), 1'b1);
        checkOutput("bp release in_ready", 64'(in_ready), 64'd1);
        checkOutput("bp drain 0", out_data, bpExpected(0));
        for (int n = 1; n < 4; n++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("bp drain out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp drain out_data", out_data, bpExpected(n));
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("bp empty out_valid", 64'(out_valid), 64'd0);
        checkOutput("bp empty occupancy", 64'(occupancy), 64'd0);

        applyStimulus(1'b1, pack(32'h11, 32'h22, 32'h33, 32'h44), 1'b1);
        applyStimulus(1'b1, pack(32'h55, 32'h66, 32'h77, 32'h88), 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("pre-reset occupancy", 64'(occupancy), 64'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset occupancy", 64'(occupancy), 64'd0);
        checkOutput("midreset out_data", out_data, 64'd0);
        applyStimulus(1'b1, pack(32'h9, 32'h9, 32'h9, 32'h9), 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("midreset no capture", 64'(occupancy), 64'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("post-reset out_valid", 64'(out_valid), 64'd0);
        end
        sendWord("post-reset", pack(32'h00000003, 32'h00000004, 32'hFFFFFFF0, 32'h00000020), 64'h00000010_00000007);
`ifdef PIPE_LANE_ADDER_CARRY_EN
        checkOutput("post-reset carry", 64'(carry), 64'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
